// File: rtl/gemm_c_drain.sv
// ----------------------------------------------------------------------------
// gemm_c_drain
//
// Consumer end of the GEMM result interface. Every strobe on io_data_in_valid
// captures one C_WIDTH-bit C tile into a small circular buffer. The oldest
// buffered tile is streamed out as BEATS = C_WIDTH/OUT_WIDTH beats on a
// valid/ready write port, least-significant beat first, each beat tagged with
// an incrementing byte address.
//
// Ports
//   clock            in   single clock, rising edge
//   reset            in   asynchronous, active-high
//   io_start         in   one-cycle job start: flush buffer, clear flags and
//                         counters, load io_base_addr
//   io_base_addr     in   byte address of the first beat (sampled on io_start)
//   io_data_in_valid in   C tile strobe from the GEMM core (no backpressure)
//   io_c_in          in   C tile payload
//   io_out_valid     out  beat valid
//   io_out_ready     in   sink accepts the beat
//   io_out_data      out  beat payload
//   io_out_addr      out  byte address of the current beat
//   io_out_last      out  current beat is the final beat of its tile
//   io_busy          out  buffer non-empty
//   io_overflow      out  sticky: a tile was dropped because the buffer was full
//   io_tile_count    out  tiles fully drained since the last start
//
// Handshake: a beat transfers on a rising edge where io_out_valid and
// io_out_ready are both 1. Once io_out_valid is raised it stays raised, and
// io_out_data/io_out_addr/io_out_last stay stable, until that transfer occurs
// (only io_start or reset can withdraw a pending beat).
//
// The FSM state is held in the `state` register (IDLE/STREAM) so checkers can
// bind to it directly.
// ----------------------------------------------------------------------------
module gemm_c_drain #(
    parameter int C_WIDTH    = 2048,
    parameter int OUT_WIDTH  = 256,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic [ADDR_WIDTH-1:0] io_base_addr,
    input  logic                  io_data_in_valid,
    input  logic [C_WIDTH-1:0]    io_c_in,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [OUT_WIDTH-1:0]  io_out_data,
    output logic [ADDR_WIDTH-1:0] io_out_addr,
    output logic                  io_out_last,
    output logic                  io_busy,
    output logic                  io_overflow,
    output logic [15:0]           io_tile_count
);

    localparam int BEATS  = C_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(OUT_WIDTH / 8);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0]      LAST_SLOT  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state;
    logic                    out_valid;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [BEAT_W-1:0]       beat;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    overflow;
    logic [15:0]             tile_count;

    // Tile storage carries no reset: its contents are only ever observed
    // through slots that have been written since the last flush.
    logic [C_WIDTH-1:0]      buffer [DEPTH];

    // ------------------------------------------------------------------
    // Handshake and buffer control
    // ------------------------------------------------------------------
    logic                    fire;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic [CNT_W-1:0]        count_next;
    logic                    buf_we;
    logic [PTR_W-1:0]        buf_widx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
    endfunction

    assign fire = out_valid && io_out_ready;
    // The head tile leaves the buffer when its final beat transfers.
    assign pop  = fire && (beat == LAST_BEAT);
    // A full buffer still accepts a tile in the cycle its head slot frees up;
    // the new tile lands in that very slot (wr_ptr == rd_ptr when full).
    assign push = io_data_in_valid && ((count < FULL_COUNT) || pop);
    assign drop = io_data_in_valid && !push;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // On io_start the buffer is flushed first, so a coincident tile goes
    // into slot 0 of the now-empty buffer.
    always_comb begin
        buf_we   = push;
        buf_widx = wr_ptr;
        if (io_start) begin
            buf_we   = io_data_in_valid;
            buf_widx = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (buf_we) begin
            buffer[buf_widx] <= io_c_in;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, pointers, counters and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat       <= '0;
            addr       <= '0;
            overflow   <= 1'b0;
            tile_count <= '0;
        end else if (io_start) begin
            // Abandons any in-flight beat; the handshake restarts cleanly.
            state      <= IDLE;
            out_valid  <= 1'b0;
            rd_ptr     <= '0;
            beat       <= '0;
            addr       <= io_base_addr;
            overflow   <= 1'b0;
            tile_count <= '0;
            if (io_data_in_valid) begin
                wr_ptr <= next_ptr('0);
                count  <= CNT_W'(1);
            end else begin
                wr_ptr <= '0;
                count  <= '0;
            end
        end else begin
            count <= count_next;

            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end

            if (drop) begin
                overflow <= 1'b1;
            end

            if (fire) begin
                addr <= addr + ADDR_STEP;
                if (pop) begin
                    beat       <= '0;
                    rd_ptr     <= next_ptr(rd_ptr);
                    tile_count <= tile_count + 16'd1;
                end else begin
                    beat <= beat + BEAT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    // Uses the registered count, so a tile captured into an
                    // empty buffer is presented one cycle after capture.
                    if (count != '0) begin
                        state     <= STREAM;
                        out_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (pop && (count_next == '0)) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat selection: beat 0 carries the least-significant OUT_WIDTH bits.
    // ------------------------------------------------------------------
    logic [C_WIDTH-1:0]   head_tile;
    logic [OUT_WIDTH-1:0] head_beats [BEATS];

    assign head_tile = buffer[rd_ptr];

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign head_beats[b] = head_tile[b*OUT_WIDTH +: OUT_WIDTH];
    end

    // ------------------------------------------------------------------
    // Outputs. Payload is forced to zero while no beat is offered so the
    // port reads all-zero straight out of reset.
    // ------------------------------------------------------------------
    assign io_out_valid  = out_valid;
    assign io_out_data   = out_valid ? head_beats[beat] : '0;
    assign io_out_addr   = addr;
    assign io_out_last   = out_valid && (beat == LAST_BEAT);
    assign io_busy       = (count != '0);
    assign io_overflow   = overflow;
    assign io_tile_count = tile_count;

endmodule

// File: tb/tb_gemm_c_drain.sv
// ----------------------------------------------------------------------------
// tb_gemm_c_drain
//
// Directed scenarios plus a randomized phase for gemm_c_drain. A queue-based
// reference model tracks the buffered tiles, beat position, address, drained
// tile count and overflow flag; every cycle all DUT outputs are compared with
// it, and directed scenarios add explicit checks against constant values.
// ----------------------------------------------------------------------------
module tb_gemm_c_drain;

    localparam int C_W    = 2048;
    localparam int O_W    = 256;
    localparam int DEPTH  = 2;
    localparam int A_W    = 32;
    localparam int BEATS  = C_W / O_W;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           io_start = 1'b0;
    logic [A_W-1:0] io_base_addr = '0;
    logic           io_data_in_valid = 1'b0;
    logic [C_W-1:0] io_c_in = '0;
    logic           io_out_valid;
    logic           io_out_ready = 1'b0;
    logic [O_W-1:0] io_out_data;
    logic [A_W-1:0] io_out_addr;
    logic           io_out_last;
    logic           io_busy;
    logic           io_overflow;
    logic [15:0]    io_tile_count;

    always #5 clock = ~clock;

    gemm_c_drain #(
        .C_WIDTH   (C_W),
        .OUT_WIDTH (O_W),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(A_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_start        (io_start),
        .io_base_addr    (io_base_addr),
        .io_data_in_valid(io_data_in_valid),
        .io_c_in         (io_c_in),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_data     (io_out_data),
        .io_out_addr     (io_out_addr),
        .io_out_last     (io_out_last),
        .io_busy         (io_busy),
        .io_overflow     (io_overflow),
        .io_tile_count   (io_tile_count)
    );

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    int             tests = 0;
    int             fails = 0;

    logic [C_W-1:0] exp_q[$];     // buffered tiles, head first
    bit             m_valid;      // a beat is being offered
    int             m_beat;
    logic [A_W-1:0] m_addr;
    logic [15:0]    m_tcnt;
    bit             m_ovf;

    task automatic check(input string tag, input logic [O_W-1:0] obs,
                         input logic [O_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [C_W-1:0] make_tile(input int kind);
        logic [C_W-1:0] t;
        for (int i = 0; i < C_W / 32; i++) begin
            case (kind)
                0:       t[i*32 +: 32] = 32'h0101_0101;
                1:       t[i*32 +: 32] = 32'(i);
                2:       t[i*32 +: 32] = 32'(63 - i);
                default: t[i*32 +: 32] = $urandom;
            endcase
        end
        return t;
    endfunction

    function automatic logic [O_W-1:0] beat_of(input logic [C_W-1:0] t, input int k);
        return t[k*O_W +: O_W];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_valid = 0;
        m_beat  = 0;
        m_addr  = '0;
        m_tcnt  = '0;
        m_ovf   = 0;
    endtask

    // Applies one rising edge worth of behaviour, using the inputs the bench
    // is driving at that edge.
    task automatic model_update();
        int  pre_size;
        bit  fire;
        bit  last_fire;
        if (reset) begin
            model_reset();
            return;
        end
        if (io_start) begin
            model_reset();
            m_addr = io_base_addr;
            if (io_data_in_valid) exp_q.push_back(io_c_in);
            return;
        end
        pre_size  = exp_q.size();
        fire      = m_valid && io_out_ready;
        last_fire = fire && (m_beat == BEATS - 1);
        if (fire) begin
            m_addr = m_addr + 32'(O_W / 8);
            if (last_fire) begin
                void'(exp_q.pop_front());
                m_tcnt = m_tcnt + 16'd1;
                m_beat = 0;
            end else begin
                m_beat = m_beat + 1;
            end
        end
        if (io_data_in_valid) begin
            if (pre_size < DEPTH || last_fire) exp_q.push_back(io_c_in);
            else m_ovf = 1;
        end
        if (!m_valid) m_valid = (pre_size > 0);
        else if (last_fire) m_valid = (exp_q.size() > 0);
    endtask

    task automatic check_all();
        logic [C_W-1:0] head;
        logic [O_W-1:0] exp_data;
        exp_data = '0;
        if (m_valid && exp_q.size() > 0) begin
            head     = exp_q[0];
            exp_data = beat_of(head, m_beat);
        end
        check("m_valid", O_W'(io_out_valid), O_W'(m_valid));
        check("m_data", io_out_data, exp_data);
        check("m_addr", O_W'(io_out_addr), O_W'(m_addr));
        check("m_last", O_W'(io_out_last), O_W'(m_valid && m_beat == BEATS - 1));
        check("m_busy", O_W'(io_busy), O_W'(exp_q.size() != 0));
        check("m_ovf", O_W'(io_overflow), O_W'(m_ovf));
        check("m_tcnt", O_W'(io_tile_count), O_W'(m_tcnt));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_all();
    endtask

    task automatic start_job(input logic [A_W-1:0] base);
        io_start     = 1'b1;
        io_base_addr = base;
        step();
        io_start     = 1'b0;
    endtask

    task automatic push_tile(input logic [C_W-1:0] t);
        io_c_in          = t;
        io_data_in_valid = 1'b1;
        step();
        io_data_in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [C_W-1:0] ramp;
    logic [C_W-1:0] ones;
    logic [C_W-1:0] desc;
    logic [O_W-1:0] got[$];
    logic [O_W-1:0] pd;
    logic [A_W-1:0] pa;
    logic           pl;
    bit             stalled;
    int             fires;
    int             n;
    bit             pat [3];

    initial begin
        ramp = make_tile(1);
        ones = make_tile(0);
        desc = make_tile(2);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        model_reset();

        // --- reset state ---
        step();
        step();
        check("rst_valid", O_W'(io_out_valid), '0);
        check("rst_addr", O_W'(io_out_addr), '0);
        check("rst_tcnt", O_W'(io_tile_count), '0);
        reset = 1'b0;

        // --- basic drain ---
        start_job(32'h1000);
        io_out_ready = 1'b1;
        push_tile(ramp);
        check("lat_capture_edge", O_W'(io_out_valid), '0);
        step();
        check("lat_next_edge", O_W'(io_out_valid), O_W'(1));
        for (int k = 0; k < BEATS; k++) begin
            check("basic_data", io_out_data, beat_of(ramp, k));
            check("basic_addr", O_W'(io_out_addr), O_W'(32'h1000 + 32 * k));
            check("basic_last", O_W'(io_out_last), O_W'(k == BEATS - 1));
            step();
        end
        check("basic_tcnt", O_W'(io_tile_count), O_W'(1));
        check("basic_idle", O_W'(io_out_valid), '0);

        // --- backpressure ---
        start_job(32'h1000);
        push_tile(ramp);
        got.delete();
        stalled = 0;
        n = 0;
        while (io_tile_count != 16'd1 && n < 80) begin
            if (stalled) begin
                check("bp_hold_data", io_out_data, pd);
                check("bp_hold_addr", O_W'(io_out_addr), O_W'(pa));
                check("bp_hold_last", O_W'(io_out_last), O_W'(pl));
            end
            io_out_ready = pat[n % 3];
            if (io_out_valid && io_out_ready) got.push_back(io_out_data);
            stalled = io_out_valid && !io_out_ready;
            pd = io_out_data; pa = io_out_addr; pl = io_out_last;
            step();
            n++;
        end
        check("bp_fires", O_W'(got.size()), O_W'(BEATS));
        if (got.size() == BEATS)
            for (int k = 0; k < BEATS; k++) check("bp_beat", got[k], beat_of(ramp, k));

        // --- overflow ---
        start_job(32'h0);
        io_out_ready = 1'b0;
        push_tile(ones);
        push_tile(ramp);
        push_tile(desc);
        check("ovf_set", O_W'(io_overflow), O_W'(1));
        io_out_ready = 1'b1;
        got.delete();
        n = 0;
        while (got.size() < 2 * BEATS && n < 60) begin
            if (io_out_valid && io_out_ready) got.push_back(io_out_data);
            step();
            n++;
        end
        check("ovf_beats", O_W'(got.size()), O_W'(2 * BEATS));
        if (got.size() == 2 * BEATS) begin
            for (int k = 0; k < BEATS; k++) check("ovf_first", got[k], beat_of(ones, k));
            for (int k = 0; k < BEATS; k++) check("ovf_second", got[BEATS + k], beat_of(ramp, k));
        end
        check("ovf_tcnt", O_W'(io_tile_count), O_W'(2));

        // --- capture on last beat ---
        start_job(32'h0);
        io_out_ready = 1'b0;
        push_tile(ones);
        push_tile(ramp);
        step();
        io_out_ready = 1'b1;
        n = 0;
        while (!io_out_last && n < 20) begin
            step();
            n++;
        end
        check("cl_reach_last", O_W'(io_out_last), O_W'(1));
        push_tile(desc);
        check("cl_ovf", O_W'(io_overflow), '0);
        check("cl_tcnt", O_W'(io_tile_count), O_W'(1));
        fires = 0;
        n = 0;
        while (io_tile_count != 16'd3 && n < 60) begin
            if (io_out_valid && io_out_ready) fires++;
            step();
            n++;
        end
        check("cl_remaining_fires", O_W'(fires), O_W'(2 * BEATS));
        check("cl_tcnt_end", O_W'(io_tile_count), O_W'(3));

        // --- start mid-tile ---
        start_job(32'h0);
        io_out_ready = 1'b0;
        push_tile(ones);
        push_tile(ramp);
        push_tile(desc);
        check("sm_ovf_before", O_W'(io_overflow), O_W'(1));
        io_out_ready = 1'b1;
        fires = 0;
        n = 0;
        while (fires < 4 && n < 20) begin
            if (io_out_valid && io_out_ready) fires++;
            step();
            n++;
        end
        check("sm_fires", O_W'(fires), O_W'(4));
        start_job(32'h2000);
        check("sm_valid", O_W'(io_out_valid), '0);
        check("sm_tcnt", O_W'(io_tile_count), '0);
        check("sm_ovf", O_W'(io_overflow), '0);
        push_tile(ramp);
        step();
        check("sm_new_valid", O_W'(io_out_valid), O_W'(1));
        check("sm_new_addr", O_W'(io_out_addr), O_W'(32'h2000));
        check("sm_new_data", io_out_data, beat_of(ramp, 0));
        n = 0;
        while (io_tile_count != 16'd1 && n < 30) begin
            step();
            n++;
        end
        check("sm_drained", O_W'(io_tile_count), O_W'(1));

        // --- reset mid-stream ---
        start_job(32'h4000);
        io_out_ready = 1'b1;
        push_tile(desc);
        fires = 0;
        n = 0;
        while (fires < 5 && n < 20) begin
            if (io_out_valid && io_out_ready) fires++;
            step();
            n++;
        end
        check("rm_beat5_addr", O_W'(io_out_addr), O_W'(32'h4000 + 5 * 32));
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("rm_valid", O_W'(io_out_valid), '0);
        check("rm_data", io_out_data, '0);
        check("rm_addr", O_W'(io_out_addr), '0);
        check("rm_last", O_W'(io_out_last), '0);
        check("rm_busy", O_W'(io_busy), '0);
        check("rm_ovf", O_W'(io_overflow), '0);
        check("rm_tcnt", O_W'(io_tile_count), '0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rm_quiet", O_W'(io_out_valid), '0);
        end
        push_tile(ramp);
        for (int i = 0; i < BEATS + 3; i++) step();
        check("rm_after_tcnt", O_W'(io_tile_count), O_W'(1));

        // --- randomized traffic ---
        for (int i = 0; i < 400; i++) begin
            io_start         = ($urandom_range(0, 59) == 0);
            io_base_addr     = $urandom;
            io_data_in_valid = ($urandom_range(0, 3) == 0);
            io_c_in          = make_tile(3);
            io_out_ready     = ($urandom_range(0, 3) != 0);
            step();
        end
        io_start         = 1'b0;
        io_data_in_valid = 1'b0;
        io_out_ready     = 1'b1;
        for (int i = 0; i < 2 * BEATS * DEPTH + 4; i++) step();
        check("rand_drained", O_W'(io_busy), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gemm_c_drain.md
Name: gemm_c_drain

Overview:
- Consumer end of the GEMM result interface. Captures each 2048-bit C tile when the GEMM core asserts its output-valid strobe.
- Buffers up to DEPTH tiles and streams each tile out as OUT_WIDTH-bit beats on a valid/ready write port, with an incrementing byte address.
- Sits between the Gemm core's io_data_out_valid/io_c_io_out outputs and the memory-side writer.

Parameters:
- C_WIDTH, 2048: width of one C tile, i.e. 64 x 32-bit elements.
- OUT_WIDTH, 256: width of one output beat. Must divide C_WIDTH. BEATS = C_WIDTH/OUT_WIDTH (8 at defaults).
- DEPTH, 2: number of tile buffer slots. Must be ≥1.
- ADDR_WIDTH, 32: width of the output address.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- io_start  in  1  one-cycle pulse that begins a job: flushes the buffer, clears flags and counters, loads io_base_addr.
- io_base_addr  in  ADDR_WIDTH  byte address of the first beat; sampled only when io_start=1.
- io_data_in_valid  in  1  C tile valid; connects to GEMM io_data_out_valid. Single-cycle strobe, no backpressure to the producer.
- io_c_in  in  C_WIDTH  C tile; connects to GEMM io_c_io_out.
- io_out_valid  out  1  beat valid.
- io_out_ready  in  1  sink accepts the beat.
- io_out_data  out  OUT_WIDTH  beat payload.
- io_out_addr  out  ADDR_WIDTH  byte address of the current beat.
- io_out_last  out  1  current beat is beat BEATS-1 of its tile.
- io_busy  out  1  buffer non-empty.
- io_overflow  out  1  sticky: a tile arrived while the buffer was full and was dropped.
- io_tile_count  out  16  tiles fully drained since the last start.

Behaviour:
- Reset values (asynchronous): all outputs 0; buffer empty; beat index 0; address register 0; FSM in IDLE.
- Storage: circular buffer of DEPTH slots, with wr_ptr, rd_ptr and occupancy count (0..DEPTH).
- Fire: a beat fires when io_out_valid && io_out_ready.
- Capture:
  - When io_data_in_valid=1 and (count<DEPTH, or the last beat of the head tile fires this same cycle), io_c_in is written to slot wr_ptr. wr_ptr and count update.
  - Simultaneous capture and pop leaves count unchanged.
- Overflow: if io_data_in_valid=1 while count==DEPTH and no pop occurs, the tile is dropped and io_overflow is set. It stays set until io_start or reset.
- Latency: a tile captured at edge N gives io_out_valid=1 from cycle N+1 when the buffer was empty.
- FSM:
  - IDLE: io_out_valid=0. Moves to STREAM when count>0.
  - STREAM: io_out_valid=1.
    - On each fire, the beat index increments and the address increases by OUT_WIDTH/8 (32).
    - On firing beat BEATS-1: beat index returns to 0, rd_ptr advances, count decrements (unless a capture occurs the same cycle), io_tile_count increments.
    - After that last beat, stay in STREAM if count stays >0, else go to IDLE.
- Beat mapping: io_out_data = head_slot[(beat+1)*OUT_WIDTH-1 : beat*OUT_WIDTH]. Beat 0 carries the LSBs.
- io_out_last = (beat == BEATS-1) && io_out_valid.
- Hold rule: while io_out_valid && !io_out_ready, io_out_data, io_out_addr and io_out_last hold stable.
- Address arithmetic: io_out_addr wraps modulo 2^ADDR_WIDTH. io_tile_count wraps modulo 2^16.
- io_start, at any time including mid-tile:
  - Empties the buffer, zeroes the beat index and io_tile_count, clears io_overflow, loads the address register with io_base_addr, and forces IDLE.
  - The in-flight beat is abandoned; io_out_valid=0 in the next cycle.
- io_start with io_data_in_valid in the same cycle: the flush applies first, then the tile is captured into an empty buffer, so count=1 next cycle.
- Reset asserted mid-operation: immediate return to reset values, with no beat emitted.
- io_busy = (count != 0).

Test Plan:
- Basic drain:
  - Stimulus: start with base 0x1000; one tile whose 32-bit element i = i; ready held 1.
  - Required: 8 consecutive beats, with beat 0 = {32'd7,…,32'd0} and beat 7 = {32'd63,…,32'd56}.
  - Required: addresses 0x1000..0x10E0 in steps of 0x20; last=1 only on beat 7; tile_count=1.
  - Required: valid rises exactly 1 cycle after capture.
- Backpressure:
  - Stimulus: same tile; ready toggles 1,0,0,1,…
  - Required: data and addr stable across stalls; exactly 8 fires; no beat lost or duplicated.
- Overflow:
  - Stimulus: ready=0; three tiles (all 8'h1-pattern, then ramp, then descending) on consecutive cycles.
  - Required: first two buffered; overflow=1 after the third; once ready=1, 16 beats emerge, first tile's beats then second tile's.
- Capture on last beat:
  - Stimulus: DEPTH=2 full; a new tile strobes in the cycle beat 7 of the head tile fires.
  - Required: tile accepted, overflow stays 0, count stays 2.
- Start mid-tile:
  - Stimulus: io_start with base 0x2000 after beat 3 fires.
  - Required: valid=0 next cycle; tile_count=0; overflow cleared.
  - Required: a subsequent tile drains starting at address 0x2000, beginning with beat 0.
- Reset mid-stream:
  - Stimulus: assert reset asynchronously between clock edges during beat 5.
  - Required: all outputs read 0 immediately; after release, valid stays 0 until a new tile arrives.
